disp_ram_arbiter: RTL and testbench
===================================

# disp_ram_arbiter

Arbiter for the single shared port A of the 256-byte CHIP-8 display RAM. It serves three requesters: host (bus) writes, the CPU (draw/clear reads and writes), and VGA scanout reads. Priority is fixed at host > CPU > display, with a starvation guard so scanout is never blocked indefinitely by the CPU. It sits in the top level between the bus decode, the cpu instance, the display instance and display_ram.

## Interface
- AW, 8, display RAM address width (256 bytes = 64x32 pixels / 8).
- DW, 8, data width.
- MAX_WAIT, 4, number of consecutive denied display cycles after which the display outranks the CPU (1..15).

- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_req  in  1  host write request; held until host_ack.
- host_addr  in  AW  host write address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  host write committed this cycle (combinational).
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid (registered).
- cpu_rdata  out  DW  read data for the CPU.
- disp_req  in  1  scanout read request; held until disp_gnt.
- disp_addr  in  AW  scanout address.
- disp_gnt  out  1  scanout read issued this cycle (combinational).
- disp_rvalid  out  1  disp_rdata valid (registered).
- disp_rdata  out  DW  read data for the display.
- ram_a  out  AW  RAM port A address.
- ram_d  out  DW  RAM port A write data.
- ram_w  out  1  RAM port A write enable.
- ram_q  in  DW  RAM port A read data, valid one cycle after its address.

## Operation
- At most one grant per cycle; a grant drives ram_a, ram_d and ram_w in the same cycle.
- Normal priority: host_req, then cpu_req, then disp_req.
- Starvation counter wait_cnt (4-bit):
  - Increments, saturating at MAX_WAIT, in each cycle where disp_req=1 and disp_gnt=0.
  - Clears to 0 on disp_gnt or disp_req=0.
- While wait_cnt == MAX_WAIT, priority is host > display > CPU. The host is never preempted.
- Write enable: ram_w = host_ack | (cpu_gnt & cpu_we).
- Data and address mux:
  - ram_d = host_wdata on a host grant, otherwise cpu_wdata.
  - ram_a = address of the granted requester; 0 when idle.
- Read tagging: a one-stage registered tag {cpu_rd, disp_rd} records which read was issued.
  - Next cycle, the tagged requester's rvalid is 1.
  - cpu_rdata and disp_rdata both pass ram_q through directly.
- CPU writes produce no cpu_rvalid.
- A requester may hold req after its grant to issue back-to-back accesses; each cycle with a grant is a separate access.
- Requests are sampled combinationally. A req dropped before its grant is simply never served; no state is kept.

## Timing
- Reset (reset_n low, asynchronous):
  - wait_cnt = 0, read tag cleared, cpu_rvalid = disp_rvalid = 0.
  - All grants and ram_w forced to 0, and ram_a = 0 while reset_n is low.
- Grant latency: 0 cycles (same cycle as req when it wins arbitration).
- Read latency: address in cycle T, rvalid and rdata in cycle T+1. Full throughput of one access per cycle.
- A read issued in the cycle reset asserts never produces rvalid.
- Simultaneous host_req, cpu_req and disp_req with wait_cnt < MAX_WAIT: host wins. The CPU and display each wait.
- Continuous host_req starves both other requesters indefinitely (allowed; the host halts the CPU externally). wait_cnt stays saturated at MAX_WAIT.
- Display forced grant: on the first cycle with wait_cnt == MAX_WAIT and no host_req, disp_gnt = 1 and cpu_gnt = 0. wait_cnt returns to 0 the next cycle.

## Test plan
- Reset: hold reset_n=0 with all reqs=1 -> all grants=0, ram_w=0, rvalids=0. Release -> host_ack=1 on the first edge-following cycle.
- Host write: host_req=1, addr=0x10, data=0xA5 -> host_ack=1, ram_a=0x10, ram_d=0xA5, ram_w=1 in the same cycle. No rvalid next cycle.
- CPU read: preload RAM[0x20]=0x3C; cpu_req=1, we=0, addr=0x20 -> cpu_gnt=1 at T; cpu_rvalid=1 and cpu_rdata=0x3C at T+1. disp_rvalid=0.
- Contention: cpu_req and disp_req held continuously, MAX_WAIT=4 -> grant sequence CPU,CPU,CPU,CPU,DISP,CPU,... wait_cnt goes 1,2,3,4 then 0.
- Host priority over starvation: wait_cnt=MAX_WAIT plus host_req=1 -> host_ack=1, disp_gnt=0, wait_cnt stays 4. host_req drops -> disp_gnt=1 next cycle.
- Back-to-back reads: disp_req held with addr 0..3 and no other reqs -> disp_rvalid=1 on four consecutive cycles with data matching RAM[0..3] in order.

Source files
------------

// File: rtl/disp_ram_arbiter.sv
// disp_ram_arbiter
//
// Arbitrates the single port A of the 256-byte CHIP-8 display RAM between
// host writes, CPU reads/writes and VGA scanout reads.
// Priority is host > CPU > display. A starvation counter lets the display
// outrank the CPU after MAX_WAIT consecutive denied cycles. The host is
// never preempted.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   host_req/addr/wdata, host_ack     host write channel (ack is combinational)
//   cpu_req/we/addr/wdata, cpu_gnt    CPU access channel (gnt is combinational)
//   cpu_rvalid, cpu_rdata             CPU read return, one cycle after cpu_gnt
//   disp_req/addr, disp_gnt           scanout read channel (gnt is combinational)
//   disp_rvalid, disp_rdata           scanout read return, one cycle after disp_gnt
//   ram_a, ram_d, ram_w, ram_q        RAM port A (ram_q valid one cycle after ram_a)

module disp_ram_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          host_req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,

    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_w,
    input  logic [DW-1:0] ram_q
);

    localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       cpu_rd_q, disp_rd_q;
    logic       starved;
    logic       disp_first;

    // Grants. All are gated by reset_n so nothing reaches the RAM while reset
    // is held, even though the requests are sampled combinationally.
    always_comb begin
        starved    = (wait_cnt_q == WaitMax);
        // Display outranks the CPU only while it is actually asking.
        disp_first = starved & disp_req;

        host_ack = reset_n & host_req;
        cpu_gnt  = reset_n & ~host_req & cpu_req & ~disp_first;
        disp_gnt = reset_n & ~host_req & disp_req & (disp_first | ~cpu_req);

        ram_w = host_ack | (cpu_gnt & cpu_we);
        ram_d = host_ack ? host_wdata : cpu_wdata;

        if (host_ack) begin
            ram_a = host_addr;
        end else if (cpu_gnt) begin
            ram_a = cpu_addr;
        end else if (disp_gnt) begin
            ram_a = disp_addr;
        end else begin
            ram_a = '0;
        end
    end

    // Starvation counter: counts consecutive denied display cycles, saturating.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!disp_req || disp_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= 4'd0;
            cpu_rd_q   <= 1'b0;
            disp_rd_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            // Read tag: which requester owns the data arriving on ram_q next cycle.
            cpu_rd_q   <= cpu_gnt & ~cpu_we;
            disp_rd_q  <= disp_gnt;
        end
    end

    assign cpu_rvalid  = cpu_rd_q;
    assign disp_rvalid = disp_rd_q;
    assign cpu_rdata   = ram_q;
    assign disp_rdata  = ram_q;

endmodule

// File: tb/tb_disp_ram_arbiter.sv
module tb_disp_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       host_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, disp_req = 1'b0;
    logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00, disp_addr = 8'h00;
    logic       host_ack, cpu_gnt, cpu_rvalid, disp_gnt, disp_rvalid, ram_w;
    logic [7:0] cpu_rdata, disp_rdata, ram_a, ram_d;
    logic [7:0] ram_q = 8'h00;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] g;   // {host_ack, cpu_gnt, disp_gnt}
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] disp_q[$];
    logic [7:0] shadow [256];
    logic [7:0] ram [256];

    disp_ram_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_rvalid(disp_rvalid),
        .disp_rdata (disp_rdata),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_w      (ram_w),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            0: return 8'h11;
            1: return 8'h22;
            2: return 8'h33;
            3: return 8'h44;
            32: return 8'h3C;
            default: return 8'h00;
        endcase
    endfunction

    // Display RAM model; preloaded while reset is held.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (ram_w) begin
            ram[ram_a] <= ram_d;
        end
        ram_q <= ram[ram_a];
    end

    // Drive one cycle of requests and push the hand-chosen grant outcome.
    task automatic step(input logic rn, input logic hr, input logic [7:0] ha, input logic [7:0] hd,
                        input logic cr, input logic cwe, input logic [7:0] ca,
                        input logic [7:0] cd, input logic dr, input logic [7:0] da,
                        input logic [2:0] eg);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rn;
        host_req = hr; host_addr = ha; host_wdata = hd;
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        disp_req = dr; disp_addr = da;
        e.g = eg;
        e.w = eg[2] | (eg[1] & cwe);
        e.a = eg[2] ? ha : eg[1] ? ca : eg[0] ? da : 8'h00;
        e.d = eg[2] ? hd : cd;
        exp_q.push_back(e);
        if (eg[1] && !cwe) cpu_q.push_back(shadow[ca]);
        if (eg[0]) disp_q.push_back(shadow[da]);
        if (e.w) shadow[e.a] = e.d;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'b000);
    endtask

    // CPU write 0x40 <= 0x5A contending with display read of 0x01.
    task automatic cpu_disp(input logic dr, input logic [2:0] eg);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h5A, dr, 8'h01, eg);
    endtask

    // Monitor / scoreboard, sampling away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] x;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({host_ack, cpu_gnt, disp_gnt} !== e.g || ram_w !== e.w || ram_a !== e.a) begin
                errors++;
                $display("FAIL grant t=%0t got g=%b w=%b a=%h want g=%b w=%b a=%h", $time,
                         {host_ack, cpu_gnt, disp_gnt}, ram_w, ram_a, e.g, e.w, e.a);
            end
            if (e.w) begin
                checks++;
                if (ram_d !== e.d) begin
                    errors++;
                    $display("FAIL ram_d t=%0t got %h want %h", $time, ram_d, e.d);
                end
            end
        end
        if (cpu_rvalid !== 1'b0) begin
            checks++;
            if (cpu_q.size() == 0) begin
                errors++;
                $display("FAIL cpu_rvalid t=%0t got unexpected rvalid=%b want 0", $time, cpu_rvalid);
            end else begin
                x = cpu_q.pop_front();
                if (cpu_rdata !== x) begin
                    errors++;
                    $display("FAIL cpu_rdata t=%0t got %h want %h", $time, cpu_rdata, x);
                end
            end
        end
        if (disp_rvalid !== 1'b0) begin
            checks++;
            if (disp_q.size() == 0) begin
                errors++;
                $display("FAIL disp_rvalid t=%0t got unexpected rvalid=%b want 0", $time,
                         disp_rvalid);
            end else begin
                x = disp_q.pop_front();
                if (disp_rdata !== x) begin
                    errors++;
                    $display("FAIL disp_rdata t=%0t got %h want %h", $time, disp_rdata, x);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

        // Reset held with every request active: nothing may be granted.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00, 3'b000);
        // Release: host wins over CPU and display in the first cycle.
        step(1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00, 3'b100);
        idle();

        // CPU reads: preloaded 0x20 and the host-written 0x10.
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 3'b010);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 3'b010);
        idle();

        // Contention: four CPU grants, then the starved display wins once.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) cpu_disp(1'b1, 3'b010);
            cpu_disp(1'b1, 3'b001);
        end

        // Saturated counter but host still wins; display follows once host leaves.
        for (int i = 0; i < 4; i++) cpu_disp(1'b1, 3'b010);
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b1, 8'h50, 8'h77, 1'b1, 1'b1, 8'h40, 8'h5A, 1'b1, 8'h01, 3'b100);
        cpu_disp(1'b1, 3'b001);
        cpu_disp(1'b1, 3'b010);
        idle();

        // Back-to-back scanout reads of 0..3.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 3'b001);
        idle();

        // Dropping disp_req clears the count: starvation restarts from zero.
        for (int i = 0; i < 3; i++) cpu_disp(1'b1, 3'b010);
        cpu_disp(1'b0, 3'b010);
        for (int i = 0; i < 4; i++) cpu_disp(1'b1, 3'b010);
        cpu_disp(1'b1, 3'b001);

        // Read back CPU and host writes.
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 3'b010);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 3'b010);
        idle();
        idle();
        @(posedge clk);
        @(negedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0 || cpu_q.size() != 0 || disp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending exp=%0d cpu=%0d disp=%0d want 0 0 0",
                     exp_q.size(), cpu_q.size(), disp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
